// File: rtl/prio_encoder_pipe_pkg.sv
// Shared types and constants for the pipelined priority encoder.
`include "encoder_defs.vh"

package prio_encoder_pipe_pkg;

    typedef enum logic {
        PRIO_LSB_FIRST = `ENC_LSB_FIRST,
        PRIO_MSB_FIRST = `ENC_MSB_FIRST
    } prio_dir_e;

    localparam int PRIO_DEFAULT_CW = `ENC_DEFAULT_CW;

endpackage

// File: rtl/prio_encoder_pipe_if.sv
// Request/result bus of the pipelined priority encoder.
// valid/ready: a transfer happens on a rising edge where both valid and ready
// are 1; a source holds valid and its payload stable until that transfer.
interface prio_encoder_pipe_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_msb_first;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_zero;
    logic         out_multi;

    modport master (
        output in_valid, in_data, in_msb_first, out_ready,
        input  in_ready, out_valid, out_idx, out_zero, out_multi
    );

    modport slave (
        input  in_valid, in_data, in_msb_first, out_ready,
        output in_ready, out_valid, out_idx, out_zero, out_multi
    );
endinterface

// File: rtl/encoder_defs.vh
// Constants shared by the encoder and arbiter family: priority direction
// encodings and the default width of saturating event counters.
`ifndef ENCODER_DEFS_VH
`define ENCODER_DEFS_VH

`define ENC_LSB_FIRST   1'b0
`define ENC_MSB_FIRST   1'b1
`define ENC_DEFAULT_CW  8

`endif

// File: rtl/prio_encode_core.sv
// Combinational N-to-log2(N) priority encoder with direction select and
// zero / multi-hot detection.
module prio_encode_core
    import prio_encoder_pipe_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] in_data,
    input  logic         msb_first,
    output logic [W-1:0] idx,
    output logic         zero,
    output logic         multi
);

    logic seen;

    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        zero  = ~|in_data;
        if (msb_first == PRIO_MSB_FIRST) begin
            // Later iterations overwrite, so the highest set bit wins.
            for (int i = 0; i < N; i++) begin
                if (in_data[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_data[i]) idx = W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (in_data[i] && seen) multi = 1'b1;
            seen = seen | in_data[i];
        end
    end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Single-entry registered priority encoder with valid/ready on both sides
// and a saturating count of accepted multi-hot requests.
module prio_encoder_pipe
    import prio_encoder_pipe_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = PRIO_DEFAULT_CW,
    localparam int W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prio_encoder_pipe_if.slave   bus,
    output logic [CW-1:0]        err_cnt,
    input  logic                 clr_err
);

    logic [W-1:0]  enc_idx;
    logic          enc_zero;
    logic          enc_multi;
    logic          accept;
    logic          in_ready;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_idx_q, out_idx_d;
    logic          out_zero_q, out_zero_d;
    logic          out_multi_q, out_multi_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    prio_encode_core #(.N(N)) u_core (
        .in_data   (bus.in_data),
        .msb_first (bus.in_msb_first),
        .idx       (enc_idx),
        .zero      (enc_zero),
        .multi     (enc_multi)
    );

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_zero_d  = out_zero_q;
        out_multi_d = out_multi_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_idx_d   = enc_idx;
            out_zero_d  = enc_zero;
            out_multi_d = enc_multi;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        // Clear takes priority over a coincident multi-hot increment.
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (accept && enc_multi && (err_cnt_q != {CW{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_zero_q  <= 1'b0;
            out_multi_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_zero_q  <= out_zero_d;
            out_multi_q <= out_multi_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_multi = out_multi_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Directed bench for prio_encoder_pipe: an N=8/CW=8 instance for the main
// function and an N=8/CW=2 instance for counter saturation.
module tb_prio_encoder_pipe;

    logic       clk;
    logic       rst_n;
    logic       clr_a, clr_b;
    logic [7:0] err_a;
    logic [1:0] err_b;
    int         n_vec;
    int         n_err;

    prio_encoder_pipe_if #(.N(8)) a_if ();
    prio_encoder_pipe_if #(.N(8)) b_if ();

    prio_encoder_pipe #(.N(8), .CW(8)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (a_if),
        .err_cnt (err_a),
        .clr_err (clr_a)
    );

    prio_encoder_pipe #(.N(8), .CW(2)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (b_if),
        .err_cnt (err_b),
        .clr_err (clr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic msb);
        a_if.in_valid     = v;
        a_if.in_data      = d;
        a_if.in_msb_first = msb;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] d, input logic msb);
        b_if.in_valid     = v;
        b_if.in_data      = d;
        b_if.in_msb_first = msb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;
        drive_a(1'b0, 8'h00, 1'b0);
        drive_b(1'b0, 8'h00, 1'b0);

        // reset state
        #1;
        chk("rst_out_valid", a_if.out_valid, 0);
        chk("rst_in_ready",  a_if.in_ready, 1);
        chk("rst_err_cnt",   err_a, 0);
        #11 rst_n = 1'b1;
        tick();

        // single bit, LSB-first; in_data goes X once not valid
        drive_a(1'b1, 8'h10, 1'b0);
        tick();
        drive_a(1'b0, 8'hxx, 1'b0);
        chk("h10_valid", a_if.out_valid, 1);
        chk("h10_idx",   a_if.out_idx, 4);
        chk("h10_zero",  a_if.out_zero, 0);
        chk("h10_multi", a_if.out_multi, 0);
        chk("h10_err",   err_a, 0);

        // multi-hot in both directions
        drive_a(1'b1, 8'h5A, 1'b0);
        tick();
        chk("h5a_lsb_idx",   a_if.out_idx, 1);
        chk("h5a_lsb_multi", a_if.out_multi, 1);
        chk("h5a_lsb_err",   err_a, 1);
        drive_a(1'b1, 8'h5A, 1'b1);
        tick();
        chk("h5a_msb_idx", a_if.out_idx, 6);
        chk("h5a_msb_err", err_a, 2);

        // zero input
        drive_a(1'b1, 8'h00, 1'b0);
        tick();
        chk("zero_idx",   a_if.out_idx, 0);
        chk("zero_zero",  a_if.out_zero, 1);
        chk("zero_multi", a_if.out_multi, 0);
        chk("zero_err",   err_a, 2);

        // single bit, MSB-first, then drain with X on in_data
        drive_a(1'b1, 8'h08, 1'b1);
        tick();
        drive_a(1'b0, 8'hxx, 1'b1);
        chk("h08_msb_idx",   a_if.out_idx, 3);
        chk("h08_msb_multi", a_if.out_multi, 0);
        tick();
        chk("drain_valid", a_if.out_valid, 0);
        chk("drain_idx",   a_if.out_idx, 3);

        // backpressure
        drive_a(1'b1, 8'h01, 1'b0);
        tick();
        chk("bp_first_idx", a_if.out_idx, 0);
        a_if.out_ready = 1'b0;
        drive_a(1'b1, 8'h80, 1'b0);
        #1;
        chk("bp_in_ready_0", a_if.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_ready", a_if.in_ready, 0);
            chk("bp_hold_valid", a_if.out_valid, 1);
            chk("bp_hold_idx",   a_if.out_idx, 0);
        end
        a_if.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", a_if.in_ready, 1);
        tick();
        drive_a(1'b0, 8'h00, 1'b0);
        chk("bp_h80_valid", a_if.out_valid, 1);
        chk("bp_h80_idx",   a_if.out_idx, 7);

        // clear on A
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("clr_a_err", err_a, 0);

        // CW=2 saturation, then clear beating a multi-hot accept
        drive_b(1'b1, 8'h03, 1'b0);
        tick();
        chk("sat_err_1", err_b, 1);
        tick();
        chk("sat_err_2", err_b, 2);
        tick();
        chk("sat_err_3", err_b, 3);
        tick();
        chk("sat_err_hold", err_b, 3);
        chk("sat_multi", b_if.out_multi, 1);
        clr_b = 1'b1;
        drive_b(1'b1, 8'hC0, 1'b1);
        tick();
        clr_b = 1'b0;
        chk("clr_vs_multi_err", err_b, 0);
        chk("clr_vs_multi_idx", b_if.out_idx, 7);
        tick();
        drive_b(1'b0, 8'h00, 1'b0);
        chk("after_clr_err", err_b, 1);

        // asynchronous reset mid-cycle while holding a result
        drive_a(1'b1, 8'h22, 1'b0);
        tick();
        drive_a(1'b0, 8'h00, 1'b0);
        chk("pre_rst_valid", a_if.out_valid, 1);
        chk("pre_rst_idx",   a_if.out_idx, 1);
        chk("pre_rst_err",   err_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",    a_if.out_valid, 0);
        chk("arst_idx",      a_if.out_idx, 0);
        chk("arst_zero",     a_if.out_zero, 0);
        chk("arst_multi",    a_if.out_multi, 0);
        chk("arst_err",      err_a, 0);
        chk("arst_err_b",    err_b, 0);
        chk("arst_in_ready", a_if.in_ready, 1);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_ready", a_if.in_ready, 1);
        drive_a(1'b1, 8'h40, 1'b1);
        tick();
        drive_a(1'b0, 8'h00, 1'b0);
        chk("post_rst_valid", a_if.out_valid, 1);
        chk("post_rst_idx",   a_if.out_idx, 6);
        chk("post_rst_err",   err_a, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
